// File: rtl/mips_cpu_instr_queue.sv
// mips_cpu_instr_queue: instruction fetch queue placed between fetch and decode.
// Holds up to DEPTH {instruction, PC} entries in a circular buffer behind a
// valid/ready handshake. It presents the MIPS decode fields of the head entry,
// and forces them to zero (a NOP) when no entry is valid. A synchronous flush
// discards every queued entry on a branch or jump redirect.
//
// Optional feature: define MIPS_CPU_IQ_BYPASS_EN for a zero-latency path. While
// the queue is empty, the incoming word is presented combinationally, and it is
// consumed without being written when decode is ready.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   flush                 synchronous discard of all entries
//   in_valid/in_ready     producer handshake; memory_output, in_pc = payload
//   out_valid/out_ready   consumer handshake; out_pc = head PC
//   control_input .. jmp_address  decode fields of the head word
//   count                 current occupancy
module mips_cpu_instr_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  memory_output,
  input  logic [PC_WIDTH-1:0]          in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_WIDTH-1:0]          out_pc,
  output logic [5:0]                   control_input,
  output logic [4:0]                   source_1,
  output logic [4:0]                   source_2,
  output logic [4:0]                   dest,
  output logic [4:0]                   shamt,
  output logic [5:0]                   funct,
  output logic [15:0]                  immediate,
  output logic [25:0]                  jmp_address,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]         mem_word [DEPTH];
  logic [PC_WIDTH-1:0] mem_pc   [DEPTH];

  logic [PTR_W-1:0]    rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [CNT_W-1:0]    count_nxt;
  logic                push, pop, empty, full;
  logic [31:0]         head_word;
  logic [PC_WIDTH-1:0] head_pc;

  // Handshake decode and head selection
  always_comb begin
    empty     = (count == '0);
    full      = (count == CNT_W'(DEPTH));
    in_ready  = !full;
    out_valid = !empty;
    head_word = mem_word[rd_ptr];
    head_pc   = mem_pc[rd_ptr];
    pop       = !empty && out_ready;
    push      = in_valid && !full;
`ifdef MIPS_CPU_IQ_BYPASS_EN
    // Empty queue forwards the fetched word; it is only stored if decode stalls.
    if (empty && !flush && !reset) begin
      out_valid = in_valid;
      head_word = memory_output;
      head_pc   = in_pc;
      push      = in_valid && !out_ready;
    end
`endif
  end

  // Pointer/occupancy next state; flush overrides any handshake
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;
    if (flush) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
      count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      count  <= count_nxt;
    end
  end

  // Entry storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_word[wr_ptr] <= memory_output;
      mem_pc[wr_ptr]   <= in_pc;
    end
  end

  // Decode fields, zeroed when nothing valid is presented
  always_comb begin
    control_input = '0;
    source_1      = '0;
    source_2      = '0;
    dest          = '0;
    shamt         = '0;
    funct         = '0;
    immediate     = '0;
    jmp_address   = '0;
    out_pc        = '0;
    if (out_valid) begin
      control_input = head_word[31:26];
      source_1      = head_word[25:21];
      source_2      = head_word[20:16];
      dest          = head_word[15:11];
      shamt         = head_word[10:6];
      funct         = head_word[5:0];
      immediate     = head_word[15:0];
      jmp_address   = head_word[25:0];
      out_pc        = head_pc;
    end
  end

endmodule

// File: doc/mips_cpu_instr_queue.md
Name: mips_cpu_instr_queue

Overview:
Parametrised instruction fetch queue that replaces the single-entry instruction register. It buffers up to DEPTH fetched instruction words with their fetch PCs behind a valid/ready handshake, and presents the MIPS decode fields of the head entry to control/decode. A synchronous flush discards all queued entries on a branch or jump redirect.

Parameters:
DEPTH, 4, number of queued entries; power of two, at least 2
PC_WIDTH, 32, width of the fetch PC tag stored with each instruction

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous discard of all entries (redirect)
in_valid  in  1  memory_output/in_pc carry a fetched instruction
in_ready  out  1  queue can accept an entry this cycle
memory_output  in  32  fetched instruction word
in_pc  in  PC_WIDTH  PC of fetched instruction
out_valid  out  1  head entry valid
out_ready  in  1  decode consumes head this cycle
out_pc  out  PC_WIDTH  PC of head entry
control_input  out  6  head [31:26] opcode
source_1  out  5  head [25:21] rs
source_2  out  5  head [20:16] rt
dest  out  5  head [15:11] rd
shamt  out  5  head [10:6]
funct  out  6  head [5:0]
immediate  out  16  head [15:0]
jmp_address  out  26  head [25:0]
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (async, active-high): rd/wr pointers = 0, count = 0, out_valid = 0, in_ready = 1. All field outputs and out_pc are 0 while reset is asserted. Storage contents are don't-care.
- Circular buffer. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- in_ready = (count != DEPTH). This is combinational and does not depend on out_ready, so no push is allowed when full, even if a pop happens in the same cycle.
- out_valid = (count != 0).
- Push: in_valid && in_ready. On the clock edge, write {memory_output, in_pc} at wr_ptr, increment wr_ptr, count+1.
- Pop: out_valid && out_ready. On the clock edge, increment rd_ptr, count-1.
- Simultaneous push and pop: both pointers advance and count is unchanged.
- Latency: an entry pushed at edge N is visible on the outputs (out_valid = 1) after edge N.
- Field outputs are combinational slices of the head entry. They are forced to 0 when out_valid = 0, so an empty queue presents opcode 0 with all fields 0 (sll $0,$0,0, a NOP).
- flush: on the clock edge, count = 0 and rd_ptr = wr_ptr = 0. flush has priority over a push or pop in the same cycle; the entry offered that cycle is dropped.
- in_ready and out_valid are not masked by flush in the flush cycle. Producer and consumer must treat a handshake in the flush cycle as discarded.
- Reset asserted mid-operation clears state immediately, regardless of clk.
- Handshake rules:
  - Producer holds memory_output/in_pc stable while in_valid && !in_ready.
  - Entry order is strictly FIFO. No reordering.
  - out_ready with out_valid = 0 has no effect.

Optional Feature:
Macro MIPS_CPU_IQ_BYPASS_EN.
- Defined:
  - When count == 0 and flush == 0, out_valid = in_valid, and the field outputs and out_pc come combinationally from memory_output/in_pc.
  - If out_ready is also high, the word is consumed directly and not written, so count stays 0. If out_ready is low, the word is pushed normally.
  - This gives zero-cycle fetch-to-decode latency.
- Not defined: no combinational path from input to output; minimum latency is one cycle as above.

Test Plan:
1. Reset, then push 0x8C430004 at PC 0x00400000 → next cycle out_valid = 1, control_input = 0x23, source_1 = 2, source_2 = 3, immediate = 0x0004, out_pc = 0x00400000, count = 1.
2. DEPTH=4: push 4 words with out_ready = 0 → count = 4, in_ready = 0. A 5th in_valid is not accepted. Pop all 4 → words come out in push order, count = 0, out_valid = 0, all fields 0.
3. Wrap-around: run 10 continuous push+pop cycles with count held at 2 → count constant, output order matches input order across the pointer wrap.
4. With count = 3, assert flush together with in_valid and out_ready → next cycle count = 0, out_valid = 0, the offered word is not present, in_ready = 1.
5. Assert reset asynchronously between clock edges with count = 2 → out_valid = 0 and count = 0 before the next edge.
6. Bypass (MIPS_CPU_IQ_BYPASS_EN defined): queue empty, in_valid = out_ready = 1 with 0x08100000 → same cycle out_valid = 1, control_input = 0x02, jmp_address = 0x0100000, and count stays 0. Without the macro, out_valid = 0 in that cycle.
